// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder. Adds two DIGITS-wide BCD operands one digit
// per clock, least-significant digit first, with a start/done handshake.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   start  - request, sampled only while idle (with a, b, cin)
//   a, b   - packed BCD operands, 4*DIGITS bits
//   cin    - decimal carry-in
//   busy   - high while digits are being processed (DIGITS cycles)
//   done   - one-cycle pulse; sum/cout/err valid from this cycle on
//   sum    - packed BCD result
//   cout   - decimal carry-out of the most-significant digit
//   err    - set if any digit of a or b was greater than 9
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CMP_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                busy_d, done_d;
    logic                busy_q, done_q;

    logic [W-1:0]        a_q, b_q, acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q;
    logic                carry_q, err_acc_q;
    logic [W-1:0]        sum_q;
    logic                cout_q, err_q;

    logic                last_digit;
    logic [3:0]          a_d, b_d, digit;
    logic [CMP_W-1:0]    s_bin, s_adj;
    logic                s_gt9;
    logic                err_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next-cycle handshake outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    // One digit step: 5-bit binary sum, >9 compare selects +6 correction and carry
    always_comb begin
        last_digit = (idx_q == IDX_W'(DIGITS - 1));
        a_d        = a_q[{idx_q, 2'b00} +: 4];
        b_d        = b_q[{idx_q, 2'b00} +: 4];
        s_bin      = CMP_W'(a_d) + CMP_W'(b_d) + CMP_W'(carry_q);
        s_gt9      = (s_bin > CMP_W'(9));
        s_adj      = s_bin + CMP_W'(6);
        digit      = s_gt9 ? s_adj[3:0] : s_bin[3:0];
        err_d      = err_acc_q | (a_d > 4'd9) | (b_d > 4'd9);
        acc_d      = acc_q;
        acc_d[{idx_q, 2'b00} +: 4] = digit;
    end

    // Operand latches, digit accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            err_acc_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        carry_q   <= cin;
                        idx_q     <= '0;
                        err_acc_q <= 1'b0;
                        acc_q     <= '0;
                    end
                end
                S_ADD: begin
                    carry_q   <= s_gt9;
                    err_acc_q <= err_d;
                    acc_q     <= acc_d;
                    if (last_digit) begin
                        // Results become visible only on the edge entering DONE
                        sum_q  <= acc_d;
                        cout_q <= s_gt9;
                        err_q  <= err_d;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): a decimal reference
// model compared every cycle, plus directed vectors with literal results.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: digit-wise add with carry; invalid digits still summed
    // as plain integers, result digit is (value mod 16) after the +6 fix-up.
    function automatic logic [W+1:0] bcd_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci);
        logic [W-1:0] s;
        int           c;
        bit           e;
        int           xd, yd, t;
        s = '0;
        c = int'(ci);
        e = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            xd = int'(x[i*4 +: 4]);
            yd = int'(y[i*4 +: 4]);
            if (xd > 9 || yd > 9) e = 1'b1;
            t = xd + yd + c;
            if (t > 9) begin
                s[i*4 +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                s[i*4 +: 4] = 4'(t);
                c = 0;
            end
        end
        return {e, c[0], s};
    endfunction

    // Cycle-level model: phase 0 idle, 1..DIGITS adding, DIGITS+1 done
    int           m_phase = 0;
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic [W+1:0] m_res = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_res   <= '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_a     <= a;
                m_b     <= b;
                m_cin   <= cin;
                m_phase <= 1;
            end
        end else if (m_phase < int'(DIGITS)) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == int'(DIGITS)) begin
            m_res   <= bcd_ref(m_a, m_b, m_cin);
            m_phase <= int'(DIGITS) + 1;
        end else begin
            m_phase <= 0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= int'(DIGITS)));
            check("cyc_done", 32'(done), 32'(m_phase == int'(DIGITS) + 1));
            check("cyc_sum",  32'(sum),  32'(m_res[W-1:0]));
            check("cyc_cout", 32'(cout), 32'(m_res[W]));
            check("cyc_err",  32'(err),  32'(m_res[W+1]));
        end
    end

    // Launch one addition and wait (bounded) for done; then check literal results
    task automatic run_add(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xc, input logic [W-1:0] es, input logic ec,
                           input logic ee);
        bit seen;
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_sum"},  32'(sum),  32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_err"},  32'(err),  32'(ee));
    endtask

    int n_done;
    int busy_len;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'h0);
        repeat (3) @(negedge clk);
        check("idle_sum", 32'(sum), 32'h0);

        // Busy length for one operation
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (busy) busy_len++;
            @(negedge clk);
        end
        check("basic_busy_len", 32'(busy_len), 32'd4);
        check("basic_sum", 32'(sum), 32'h6912);
        check("basic_done", 32'(done), 32'd1);

        run_add("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_add("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_add("all9", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        run_add("bad_a", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        run_add("clear_err", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);
        run_add("allF", 16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1);
        // Back-to-back (run_add starts the cycle after done)
        run_add("b2b_1", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0);
        run_add("b2b_2", 16'h0050, 16'h0050, 1'b0, 16'h0100, 1'b0, 1'b0);

        // start held high through ADD and DONE: exactly one done pulse
        @(negedge clk);
        a = 16'h0002; b = 16'h0003; cin = 1'b0; start = 1'b1;
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b0;
            if (done) n_done++;
        end
        check("held_start_pulses", 32'(n_done), 32'd1);
        check("held_start_sum", 32'(sum), 32'h0005);

        // Operands change mid-operation: latched copies win
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h9999; b = 16'h9999; cin = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10 && n_done == 0; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midchg_done", 32'(n_done), 32'd1);
        check("midchg_sum", 32'(sum), 32'h3333);

        // Reset during the second ADD cycle aborts with no done
        @(negedge clk);
        a = 16'h0123; b = 16'h0456; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'h0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
